control_sequencer: RTL and testbench

Hardwired control unit that drives the datapath's strobe inputs (register in/out enables, PC/MAR/MDR/IR/Y/Z/HI/LO controls, memory Read/Write, ALU opcode). It replaces the hand-sequenced T0..Tn control stimulus with a clocked state machine. It fetches, decodes the instruction register, and steps one control state per clock. It sits beside the datapath and consumes only the IR contents and a run request.

---
 rtl/control_sequencer_if.sv | 34 +++
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 tb/tb_control_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | control_sequencer_if : run/IR inputs and datapath control strobes |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface control_sequencer_if;
    logic        run;
    logic [31:0] IR;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        PCout, PCin, incPC, MARin, MDRin, Read, Write, MDRout;
    logic        IRin, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, Cout;
    logic [4:0]  opcode;
    logic        halted;
    logic        illegal;
    logic [3:0]  step;

    modport master (
        input  run, IR,
        output reg_in, reg_out,
        output PCout, PCin, incPC, MARin, MDRin, Read, Write, MDRout,
        output IRin, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, Cout,
        output opcode, halted, illegal, step
    );

    modport slave (
        output run, IR,
        input  reg_in, reg_out,
        input  PCout, PCin, incPC, MARin, MDRin, Read, Write, MDRout,
        input  IRin, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, Cout,
        input  opcode, halted, illegal, step
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | control_sequencer : hardwired fetch/decode/execute control FSM    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module control_sequencer (
    input  wire logic           clk,
    input  wire logic           clr,
    control_sequencer_if.master bus
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    logic [3:0]  r_state, w_next, w_boundary;
    logic [4:0]  w_op;
    logic [15:0] w_ra, w_rb, w_rc;
    logic        w_rtype, w_muldiv, w_addi, w_ld, w_st, w_nop, w_halt, w_illegal, w_short;
    logic        w_unused_ir;

    logic [15:0] w_reg_in, w_reg_out;
    logic        w_pcout, w_pcin, w_incpc, w_marin, w_mdrin, w_read, w_write, w_mdrout;
    logic        w_irin, w_yin, w_zin, w_zlow, w_zhigh, w_hiin, w_loin, w_cout;
    logic [4:0]  w_opcode;
    logic        w_illegal_out;

    assign w_op        = bus.IR[31:27];
    assign w_ra        = 16'h0001 << bus.IR[26:23];
    assign w_rb        = 16'h0001 << bus.IR[22:19];
    assign w_rc        = 16'h0001 << bus.IR[18:15];
    assign w_unused_ir = ^bus.IR[14:0];

    always_comb begin
        w_rtype   = 1'b0;
        w_muldiv  = 1'b0;
        w_addi    = 1'b0;
        w_ld      = 1'b0;
        w_st      = 1'b0;
        w_nop     = 1'b0;
        w_halt    = 1'b0;
        w_illegal = 1'b0;
        case (w_op)
            5'b00000, 5'b00001, 5'b00010, 5'b00101,
            5'b00110, 5'b00111, 5'b01000, 5'b01001: w_rtype  = 1'b1;
            5'b00011, 5'b00100:                     w_muldiv = 1'b1;
            5'b01010:                               w_addi   = 1'b1;
            5'b01011:                               w_ld     = 1'b1;
            5'b01100:                               w_st     = 1'b1;
            5'b11000:                               w_nop    = 1'b1;
            5'b11001:                               w_halt   = 1'b1;
            default:                                w_illegal = 1'b1;
        endcase
    end

    // nop, halt and undefined opcodes all finish after the T3 decode step
    assign w_short    = w_nop | w_halt | w_illegal;
    assign w_boundary = bus.run ? S_T0 : S_IDLE;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: w_next = bus.run ? S_T0 : S_IDLE;
            S_T0:   w_next = S_T1;
            S_T1:   w_next = S_T2;
            S_T2:   w_next = S_T3;
            S_T3:   w_next = w_halt ? S_HALT : (w_short ? w_boundary : S_T4);
            S_T4:   w_next = S_T5;
            S_T5:   w_next = (w_rtype | w_addi) ? w_boundary : S_T6;
            S_T6:   w_next = w_muldiv ? w_boundary : S_T7;
            S_T7:   w_next = w_boundary;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_reg_in = 16'h0000;   w_reg_out = 16'h0000;
        w_pcout  = 1'b0; w_pcin  = 1'b0; w_incpc = 1'b0; w_marin  = 1'b0;
        w_mdrin  = 1'b0; w_read  = 1'b0; w_write = 1'b0; w_mdrout = 1'b0;
        w_irin   = 1'b0; w_yin   = 1'b0; w_zin   = 1'b0; w_zlow   = 1'b0;
        w_zhigh  = 1'b0; w_hiin  = 1'b0; w_loin  = 1'b0; w_cout   = 1'b0;
        w_opcode = 5'b00000;   w_illegal_out = 1'b0;
        case (r_state)
            S_T0: begin w_pcout = 1'b1; w_marin = 1'b1; w_incpc = 1'b1; w_zin = 1'b1; end
            S_T1: begin w_zlow = 1'b1; w_pcin = 1'b1; w_read = 1'b1; w_mdrin = 1'b1; end
            S_T2: begin w_mdrout = 1'b1; w_irin = 1'b1; end
            S_T3: begin
                if (w_short) begin
                    w_illegal_out = w_illegal;
                end else begin
                    w_reg_out = w_muldiv ? w_ra : w_rb;
                    w_yin     = 1'b1;
                end
            end
            S_T4: begin
                w_zin = 1'b1;
                if (w_rtype) begin
                    w_reg_out = w_rc;
                    w_opcode  = w_op;
                end else if (w_muldiv) begin
                    w_reg_out = w_rb;
                    w_opcode  = w_op;
                end else begin
                    w_cout = 1'b1;
                end
            end
            S_T5: begin
                w_zlow = 1'b1;
                if (w_muldiv)         w_loin   = 1'b1;
                else if (w_ld | w_st) w_marin  = 1'b1;
                else                  w_reg_in = w_ra;
            end
            S_T6: begin
                if (w_muldiv) begin
                    w_zhigh = 1'b1; w_hiin = 1'b1;
                end else if (w_st) begin
                    w_reg_out = w_ra; w_mdrin = 1'b1;
                end else begin
                    w_read = 1'b1; w_mdrin = 1'b1;
                end
            end
            S_T7: begin
                if (w_st) begin
                    w_write = 1'b1;
                end else begin
                    w_mdrout = 1'b1; w_reg_in = w_ra;
                end
            end
            default: ;
        endcase
    end

    assign bus.reg_in   = w_reg_in;
    assign bus.reg_out  = w_reg_out;
    assign bus.PCout    = w_pcout;
    assign bus.PCin     = w_pcin;
    assign bus.incPC    = w_incpc;
    assign bus.MARin    = w_marin;
    assign bus.MDRin    = w_mdrin;
    assign bus.Read     = w_read;
    assign bus.Write    = w_write;
    assign bus.MDRout   = w_mdrout;
    assign bus.IRin     = w_irin;
    assign bus.Yin      = w_yin;
    assign bus.Zin      = w_zin;
    assign bus.ZLowOut  = w_zlow;
    assign bus.ZHighOut = w_zhigh;
    assign bus.HIin     = w_hiin;
    assign bus.LOin     = w_loin;
    assign bus.Cout     = w_cout;
    assign bus.opcode   = w_opcode;
    assign bus.halted   = (r_state == S_HALT);
    assign bus.illegal  = w_illegal_out;
    assign bus.step     = r_state;
endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_control_sequencer : vector table, directed and random checks   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_control_sequencer;
    typedef logic [54:0] obs_t;   // {reg_in, reg_out, strobes, opcode, halted, illegal}

    localparam logic [15:0] PCOUT = 16'h0001, PCIN  = 16'h0002, INCPC  = 16'h0004, MARIN = 16'h0008;
    localparam logic [15:0] MDRIN = 16'h0010, READ  = 16'h0020, WRITE  = 16'h0040, MDROUT = 16'h0080;
    localparam logic [15:0] IRIN  = 16'h0100, YIN   = 16'h0200, ZIN    = 16'h0400, ZLOW  = 16'h0800;
    localparam logic [15:0] ZHIGH = 16'h1000, HIIN  = 16'h2000, LOIN   = 16'h4000, COUT  = 16'h8000;

    logic clk = 1'b0;
    logic clr;
    control_sequencer_if bus();
    control_sequencer dut (.clk(clk), .clr(clr), .bus(bus));
    always #5 clk = ~clk;

    logic [15:0] strobes;
    obs_t        obs;
    assign strobes = {bus.Cout, bus.LOin, bus.HIin, bus.ZHighOut, bus.ZLowOut, bus.Zin, bus.Yin,
                      bus.IRin, bus.MDRout, bus.Write, bus.Read, bus.MDRin, bus.MARin,
                      bus.incPC, bus.PCin, bus.PCout};
    assign obs = {bus.reg_in, bus.reg_out, strobes, bus.opcode, bus.halted, bus.illegal};

    int n_vec = 0;
    int n_err = 0;

    function automatic obs_t mk(input logic [15:0] ri, input logic [15:0] ro, input logic [15:0] st,
                                input logic [4:0] op, input logic h, input logic il);
        return {ri, ro, st, op, h, il};
    endfunction

    function automatic logic [31:0] enc(input int op, input int ra, input int rb, input int rc);
        return {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'h0};
    endfunction

    obs_t F0, F1, F2, HALTED;
    initial begin
        F0     = mk(0, 0, PCOUT | MARIN | INCPC | ZIN, 0, 0, 0);
        F1     = mk(0, 0, ZLOW | PCIN | READ | MDRIN, 0, 0, 0);
        F2     = mk(0, 0, MDROUT | IRIN, 0, 0, 0);
        HALTED = mk(0, 0, 0, 0, 1, 0);
    end

    // Reference: the whole instruction as a list of per-clock output words, starting at T0
    function automatic int model(input logic [31:0] ir, output obs_t seq [8]);
        logic [4:0]  op;
        logic [15:0] ra, rb, rc;
        op = ir[31:27];
        ra = 16'h1 << ir[26:23];
        rb = 16'h1 << ir[22:19];
        rc = 16'h1 << ir[18:15];
        foreach (seq[i]) seq[i] = '0;
        seq[0] = F0; seq[1] = F1; seq[2] = F2;
        if (op inside {5'd0, 5'd1, 5'd2, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9}) begin
            seq[3] = mk(0, rb, YIN, 0, 0, 0);
            seq[4] = mk(0, rc, ZIN, op, 0, 0);
            seq[5] = mk(ra, 0, ZLOW, 0, 0, 0);
            return 6;
        end
        if (op inside {5'd3, 5'd4}) begin
            seq[3] = mk(0, ra, YIN, 0, 0, 0);
            seq[4] = mk(0, rb, ZIN, op, 0, 0);
            seq[5] = mk(0, 0, ZLOW | LOIN, 0, 0, 0);
            seq[6] = mk(0, 0, ZHIGH | HIIN, 0, 0, 0);
            return 7;
        end
        if (op inside {5'd10, 5'd11, 5'd12}) begin
            seq[3] = mk(0, rb, YIN, 0, 0, 0);
            seq[4] = mk(0, 0, COUT | ZIN, 0, 0, 0);
            if (op == 5'd10) begin
                seq[5] = mk(ra, 0, ZLOW, 0, 0, 0);
                return 6;
            end
            seq[5] = mk(0, 0, ZLOW | MARIN, 0, 0, 0);
            seq[6] = (op == 5'd11) ? mk(0, 0, READ | MDRIN, 0, 0, 0) : mk(0, ra, MDRIN, 0, 0, 0);
            seq[7] = (op == 5'd11) ? mk(ra, 0, MDROUT, 0, 0, 0) : mk(0, 0, WRITE, 0, 0, 0);
            return 8;
        end
        seq[3] = mk(0, 0, 0, 0, 0, (op != 5'd24) && (op != 5'd25));
        return 4;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input string name, input obs_t exp, input logic r);
        check(name, obs, exp);
        bus.run = r;
        @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check(name, obs, '0);
        check({name, "_step"}, {60'h0, bus.step}, 64'h0);
    endtask

    // Precondition: at a negedge with the DUT in T0. Leaves the DUT in the next state.
    task automatic exec_instr(input string name, input logic [31:0] ir, input logic run_end);
        obs_t seq [8];
        int   n;
        bus.IR = ir;
        n = model(ir, seq);
        for (int i = 0; i < n; i++)
            step(name, seq[i], (i == n - 1) ? run_end : 1'($urandom_range(0, 1)));
    endtask

    typedef struct {
        string       name;
        logic [31:0] ir;
        int          cpi;
        logic [15:0] t3_reg_out;
    } vec_t;

    vec_t        tbl [15];
    logic [31:0] rir;
    logic        rrun;
    int          cnt;
    logic [15:0] t3ro;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{"add",   enc(0, 1, 2, 3),   6, 16'h0004};
        tbl[1]  = '{"sub",   enc(1, 4, 5, 6),   6, 16'h0020};
        tbl[2]  = '{"and",   enc(2, 7, 8, 9),   6, 16'h0100};
        tbl[3]  = '{"or",    enc(5, 2, 10, 1),  6, 16'h0400};
        tbl[4]  = '{"shr",   enc(6, 3, 11, 4),  6, 16'h0800};
        tbl[5]  = '{"shl",   enc(7, 5, 12, 0),  6, 16'h1000};
        tbl[6]  = '{"rol",   enc(9, 0, 0, 15),  6, 16'h0001};
        tbl[7]  = '{"mul",   enc(3, 6, 7, 0),   7, 16'h0040};
        tbl[8]  = '{"div",   enc(4, 15, 0, 0),  7, 16'h8000};
        tbl[9]  = '{"addi",  enc(10, 1, 9, 0),  6, 16'h0200};
        tbl[10] = '{"ld",    enc(11, 1, 2, 0),  8, 16'h0004};
        tbl[11] = '{"st",    enc(12, 3, 14, 0), 8, 16'h4000};
        tbl[12] = '{"nop",   enc(24, 5, 5, 5),  4, 16'h0000};
        tbl[13] = '{"ill31", enc(31, 1, 2, 3),  4, 16'h0000};
        tbl[14] = '{"ill13", enc(13, 1, 2, 3),  4, 16'h0000};

        // Reset held two cycles with run=1
        clr = 1'b1; bus.run = 1'b1; bus.IR = 32'h0;
        @(negedge clk); check_idle("reset_a");
        @(negedge clk); check_idle("reset_b");
        clr = 1'b0;
        @(negedge clk);

        // mul R6,R7: T0 entered one clock after release, next T0 seven clocks later
        bus.IR = 32'h1B380000;
        step("mul_t0", F0, 1); step("mul_t1", F1, 1); step("mul_t2", F2, 1);
        step("mul_t3", mk(0, 16'h0040, YIN, 0, 0, 0), 1);
        step("mul_t4", mk(0, 16'h0080, ZIN, 5'b00011, 0, 0), 1);
        step("mul_t5", mk(0, 0, ZLOW | LOIN, 0, 0, 0), 1);
        step("mul_t6", mk(0, 0, ZHIGH | HIIN, 0, 0, 0), 1);

        // add R2,R3,R2
        bus.IR = 32'h01190000;
        step("add_t0", F0, 1); step("add_t1", F1, 1); step("add_t2", F2, 1);
        step("add_t3", mk(0, 16'h0008, YIN, 0, 0, 0), 1);
        step("add_t4", mk(0, 16'h0004, ZIN, 0, 0, 0), 1);
        step("add_t5", mk(16'h0004, 0, ZLOW, 0, 0, 0), 1);

        // ld R1,C(R2) then st R1,C(R2)
        bus.IR = 32'h58900000;
        step("ld_t0", F0, 1); step("ld_t1", F1, 1); step("ld_t2", F2, 1);
        step("ld_t3", mk(0, 16'h0004, YIN, 0, 0, 0), 1);
        step("ld_t4", mk(0, 0, COUT | ZIN, 0, 0, 0), 1);
        step("ld_t5", mk(0, 0, ZLOW | MARIN, 0, 0, 0), 1);
        step("ld_t6", mk(0, 0, READ | MDRIN, 0, 0, 0), 1);
        step("ld_t7", mk(16'h0002, 0, MDROUT, 0, 0, 0), 1);
        bus.IR = 32'h60900000;
        step("st_t0", F0, 1); step("st_t1", F1, 1); step("st_t2", F2, 1);
        step("st_t3", mk(0, 16'h0004, YIN, 0, 0, 0), 1);
        step("st_t4", mk(0, 0, COUT | ZIN, 0, 0, 0), 1);
        step("st_t5", mk(0, 0, ZLOW | MARIN, 0, 0, 0), 1);
        step("st_t6", mk(0, 16'h0002, MDRIN, 0, 0, 0), 1);
        step("st_t7", mk(0, 0, WRITE, 0, 0, 0), 1);

        // Drop run during T4 of add: finishes, then IDLE is held
        bus.IR = 32'h01190000;
        step("drop_t0", F0, 1); step("drop_t1", F1, 1); step("drop_t2", F2, 1);
        step("drop_t3", mk(0, 16'h0008, YIN, 0, 0, 0), 1);
        step("drop_t4", mk(0, 16'h0004, ZIN, 0, 0, 0), 0);
        step("drop_t5", mk(16'h0004, 0, ZLOW, 0, 0, 0), 0);
        for (int i = 0; i < 3; i++) begin
            check_idle("drop_idle");
            @(negedge clk);
        end
        bus.run = 1'b1;
        @(negedge clk);

        // Undefined opcode 11111: one-cycle illegal pulse in T3, back to T0
        bus.IR = 32'hF8000000;
        step("ill_t0", F0, 1); step("ill_t1", F1, 1); step("ill_t2", F2, 1);
        step("ill_t3", mk(0, 0, 0, 0, 0, 1), 1);
        check("ill_next_t0", obs, F0);

        // Table: measured cycles per instruction and T3 bus drive
        foreach (tbl[k]) begin
            bus.IR = tbl[k].ir; bus.run = 1'b1;
            cnt = 0; t3ro = 16'hxxxx;
            do begin
                @(negedge clk);
                cnt++;
                if (cnt == 3) t3ro = bus.reg_out;
            end while (obs !== F0 && cnt < 20);
            check({tbl[k].name, "_cpi"}, cnt, tbl[k].cpi);
            check({tbl[k].name, "_t3_reg_out"}, t3ro, tbl[k].t3_reg_out);
        end

        // Random instructions against the reference model, with random run at boundaries
        for (int k = 0; k < 150; k++) begin
            rir = $urandom;
            if (rir[31:27] == 5'b11001) rir[31:27] = 5'b11000;
            rrun = ($urandom_range(0, 3) != 0);
            exec_instr("rand", rir, rrun);
            if (!rrun) begin
                check_idle("rand_idle");
                bus.run = 1'b1;
                @(negedge clk);
            end
            check("rand_t0", obs, F0);
        end

        // clr during ld T6: outputs drop without a clock edge, then IDLE
        bus.IR = 32'h58900000;
        step("clr_t0", F0, 1); step("clr_t1", F1, 1); step("clr_t2", F2, 1);
        step("clr_t3", mk(0, 16'h0004, YIN, 0, 0, 0), 1);
        step("clr_t4", mk(0, 0, COUT | ZIN, 0, 0, 0), 1);
        step("clr_t5", mk(0, 0, ZLOW | MARIN, 0, 0, 0), 1);
        check("clr_t6", obs, mk(0, 0, READ | MDRIN, 0, 0, 0));
        #2 clr = 1'b1;
        #1 check_idle("clr_async");
        bus.run = 1'b0;
        @(negedge clk); check_idle("clr_held");
        clr = 1'b0;
        @(negedge clk); check_idle("clr_idle");
        bus.run = 1'b1;
        @(negedge clk); check("clr_restart_t0", obs, F0);

        // halt: HALT is absorbing even with run=1
        bus.IR = 32'hC8000000;
        step("halt_t0", F0, 1); step("halt_t1", F1, 1); step("halt_t2", F2, 1);
        step("halt_t3", mk(0, 0, 0, 0, 0, 0), 1);
        for (int i = 0; i < 5; i++) step("halt_hold", HALTED, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
